// File: rtl/ras_replay.sv
// Return-address-stack replay engine.
// Holds the committed (architectural) return-address stack and, when the
// speculative RAS is discarded, clears it and re-pushes the architectural
// entries oldest-first so the speculative top again matches arch[0].
// Optional feature macro: RAS_REPLAY_PERF_EN adds ovf_cnt_o, a saturating
// count of committed calls that overflowed a full architectural stack.

package riscv;
    localparam int unsigned VLEN = 64;
endpackage

module ras_replay #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   commit_call_i,
    input  logic                   commit_ret_i,
    input  logic [riscv::VLEN-1:0] commit_ra_i,
    input  logic                   flush_i,
    output logic                   ras_flush_o,
    output logic                   ras_push_o,
    output logic [riscv::VLEN-1:0] ras_data_o,
    output logic                   busy_o
`ifdef RAS_REPLAY_PERF_EN
    ,
    output logic [15:0]            ovf_cnt_o
`endif
);

    localparam int unsigned VLEN  = riscv::VLEN;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        REPLAY = 2'd2
    } state_e;

    state_e           state;
    state_e           state_nxt;
    logic [VLEN-1:0]  arch [DEPTH];
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] ptr;
    logic             restart;

    // A flush always restarts; commits restart only while a replay is in
    // flight, because they change what must end up in the speculative RAS.
    assign restart = flush_i | ((commit_call_i | commit_ret_i) && (state != IDLE));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else if (clr_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: restart wins, otherwise walk CLEAR -> REPLAY -> IDLE
    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = CLEAR;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                CLEAR:   state_nxt = (count == '0) ? IDLE : REPLAY;
                REPLAY:  state_nxt = (ptr == '0) ? IDLE : REPLAY;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from state; data is zero whenever not pushing
    always_comb begin
        ras_flush_o = (state == CLEAR);
        ras_push_o  = (state == REPLAY);
        busy_o      = (state != IDLE);
        ras_data_o  = '0;
        if (state == REPLAY) begin
            ras_data_o = arch[ptr];
        end
    end

    // Architectural stack and occupancy, updated by commit strobes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) arch[i] <= '0;
            count <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) arch[i] <= '0;
            count <= '0;
        end else if (commit_call_i && commit_ret_i) begin
            // Return then call: the top entry is simply replaced.
            arch[0] <= commit_ra_i;
            if (count == '0) count <= CNT_W'(1);
        end else if (commit_call_i) begin
            arch[0] <= commit_ra_i;
            for (int i = 1; i < DEPTH; i++) arch[i] <= arch[i-1];
            if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
        end else if (commit_ret_i) begin
            for (int i = 0; i < DEPTH - 1; i++) arch[i] <= arch[i+1];
            arch[DEPTH-1] <= '0;
            if (count != '0) count <= count - CNT_W'(1);
        end
    end

    // Replay pointer: starts at the oldest valid entry, walks toward the top
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (clr_i) begin
            ptr <= '0;
        end else if (!restart) begin
            if (state == CLEAR && count != '0) begin
                ptr <= PTR_W'(count - CNT_W'(1));
            end else if (state == REPLAY && ptr != '0) begin
                ptr <= ptr - PTR_W'(1);
            end
        end
    end

`ifdef RAS_REPLAY_PERF_EN
    // Count calls that pushed the oldest entry off a full stack
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_cnt_o <= '0;
        end else if (clr_i) begin
            ovf_cnt_o <= '0;
        end else if (commit_call_i && !commit_ret_i && count == CNT_W'(DEPTH)
                     && ovf_cnt_o != 16'hFFFF) begin
            ovf_cnt_o <= ovf_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ras_replay.sv
// Directed bench for ras_replay (DEPTH=2); outputs sampled 1ns after the edge.
module tb_ras_replay;

    localparam int unsigned VLEN = riscv::VLEN;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            clr_i;
    logic            commit_call_i;
    logic            commit_ret_i;
    logic [VLEN-1:0] commit_ra_i;
    logic            flush_i;
    logic            ras_flush_o;
    logic            ras_push_o;
    logic [VLEN-1:0] ras_data_o;
    logic            busy_o;
`ifdef RAS_REPLAY_PERF_EN
    logic [15:0]     ovf_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ras_replay #(.DEPTH(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .clr_i         (clr_i),
        .commit_call_i (commit_call_i),
        .commit_ret_i  (commit_ret_i),
        .commit_ra_i   (commit_ra_i),
        .flush_i       (flush_i),
        .ras_flush_o   (ras_flush_o),
        .ras_push_o    (ras_push_o),
        .ras_data_o    (ras_data_o),
        .busy_o        (busy_o)
`ifdef RAS_REPLAY_PERF_EN
        ,
        .ovf_cnt_o     (ovf_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare {flush, push, busy, data} against the expected tuple
    task automatic chk(input string tag, input logic fl, input logic pu,
                       input logic bu, input logic [VLEN-1:0] da);
        logic [VLEN+2:0] obs;
        logic [VLEN+2:0] exp;
        obs = {ras_flush_o, ras_push_o, busy_o, ras_data_o};
        exp = {fl, pu, bu, da};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed flush/push/busy/data=%b%b%b/%0h expected %b%b%b/%0h",
                   tag, obs[VLEN+2], obs[VLEN+1], obs[VLEN], obs[VLEN-1:0],
                   fl, pu, bu, da);
        end
    endtask

    task automatic do_call(input logic [VLEN-1:0] ra);
        commit_call_i = 1'b1;
        commit_ra_i   = ra;
        step();
        commit_call_i = 1'b0;
        commit_ra_i   = '0;
    endtask

    task automatic do_ret();
        commit_ret_i = 1'b1;
        step();
        commit_ret_i = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; commit_call_i = 1'b0; commit_ret_i = 1'b0;
        commit_ra_i = '0; flush_i = 1'b0;

        // Reset state
        step(); step();
        chk("reset", 0, 0, 0, '0);
        rst_i = 1'b0;
        step();
        chk("post_reset_idle", 0, 0, 0, '0);

        // Two calls then flush: clear, push oldest, push top, idle
        do_call(64'h1000);
        chk("idle_call1_quiet", 0, 0, 0, '0);
        do_call(64'h2000);
        chk("idle_call2_quiet", 0, 0, 0, '0);
        do_flush();
        chk("two_flush", 1, 0, 1, '0);
        step();
        chk("two_push0", 0, 1, 1, 64'h1000);
        step();
        chk("two_push1", 0, 1, 1, 64'h2000);
        step();
        chk("two_done", 0, 0, 0, '0);

        // Synchronous clear empties the stack: flush yields no pushes
        do_clr();
        chk("clr_idle", 0, 0, 0, '0);
        do_flush();
        chk("clr_flush", 1, 0, 1, '0);
        step();
        chk("clr_done", 0, 0, 0, '0);

        // Overflow: three calls into depth 2 keeps 0x2, 0x3
        do_clr();
        do_call(64'h1);
        do_call(64'h2);
        do_call(64'h3);
`ifdef RAS_REPLAY_PERF_EN
        n_cmp++;
        assert (ovf_cnt_o === 16'd1) else begin
            n_err++;
            $error("FAIL ovf_cnt: observed %0d expected 1", ovf_cnt_o);
        end
`endif
        do_flush();
        chk("ovf_flush", 1, 0, 1, '0);
        step();
        chk("ovf_push0", 0, 1, 1, 64'h2);
        step();
        chk("ovf_push1", 0, 1, 1, 64'h3);
        step();
        chk("ovf_done", 0, 0, 0, '0);

        // Call then ret leaves the stack empty
        do_clr();
        do_call(64'h1000);
        do_ret();
        do_flush();
        chk("callret_flush", 1, 0, 1, '0);
        step();
        chk("callret_done", 0, 0, 0, '0);
        // Pop on empty stays empty
        do_ret();
        do_flush();
        chk("emptypop_flush", 1, 0, 1, '0);
        step();
        chk("emptypop_done", 0, 0, 0, '0);

        // Commit during replay restarts with the updated stack
        do_clr();
        do_call(64'h2000);
        do_call(64'h1000);
        do_flush();
        chk("rst_flush", 1, 0, 1, '0);
        step();
        chk("rst_first_push", 0, 1, 1, 64'h2000);
        commit_call_i = 1'b1;
        commit_ra_i   = 64'h3000;
        step();
        commit_call_i = 1'b0;
        commit_ra_i   = '0;
        chk("restart_flush", 1, 0, 1, '0);
        step();
        chk("restart_push0", 0, 1, 1, 64'h1000);
        step();
        chk("restart_push1", 0, 1, 1, 64'h3000);
        step();
        chk("restart_done", 0, 0, 0, '0);

        // Call and ret in the same cycle on empty stack: one entry
        do_clr();
        commit_call_i = 1'b1;
        commit_ret_i  = 1'b1;
        commit_ra_i   = 64'h4000;
        step();
        commit_call_i = 1'b0;
        commit_ret_i  = 1'b0;
        commit_ra_i   = '0;
        do_flush();
        chk("both_flush", 1, 0, 1, '0);
        step();
        chk("both_push", 0, 1, 1, 64'h4000);
        step();
        chk("both_done", 0, 0, 0, '0);

        // Asynchronous reset mid-replay aborts immediately
        do_clr();
        do_call(64'h1000);
        do_call(64'h2000);
        do_flush();
        step();
        chk("midrst_push0", 0, 1, 1, 64'h1000);
        rst_i = 1'b1;
        #1;
        chk("midrst_async", 0, 0, 0, '0);
        step();
        rst_i = 1'b0;
        step();
        chk("midrst_after1", 0, 0, 0, '0);
        step();
        chk("midrst_after2", 0, 0, 0, '0);
        do_flush();
        chk("midrst_flush", 1, 0, 1, '0);
        step();
        chk("midrst_empty", 0, 0, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ras_replay.md
RAS_REPLAY -- requirements
Module: ras_replay

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of architectural return-address entries (>=2).
REQ-002 SHALL take address width VLEN from riscv::VLEN; not a parameter.
REQ-003 clk_i  input  1  sole clock, all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 clr_i  input  1  synchronous clear, same effect as reset.
REQ-006 commit_call_i  input  1  committed call instruction; push commit_ra_i.
REQ-007 commit_ret_i  input  1  committed return instruction; pop.
REQ-008 commit_ra_i  input  VLEN  return address of committed call.
REQ-009 flush_i  input  1  speculative RAS discarded; request replay.
REQ-010 ras_flush_o  output  1  clear speculative RAS (drives its flush_i).
REQ-011 ras_push_o  output  1  push ras_data_o into speculative RAS (drives its push_i).
REQ-012 ras_data_o  output  VLEN  address pushed (drives its data_i).
REQ-013 busy_o  output  1  replay in progress; frontend SHALL NOT push/pop speculatively while high.

Function
REQ-014 SHALL keep an architectural stack arch[0..DEPTH-1], arch[0] = top, plus count 0..DEPTH.
REQ-015 commit_call_i only: arch[0]=commit_ra_i, others shift down, arch[DEPTH-1] dropped; count=min(count+1,DEPTH).
REQ-016 commit_ret_i only: shift up, arch[DEPTH-1]=0; count=max(count-1,0); pop on empty is a no-op on count.
REQ-017 Both in same cycle: arch[0]=commit_ra_i, no shift; count=max(count,1).
REQ-018 Arch updates visible the cycle after the commit strobe.
REQ-019 FSM states IDLE, CLEAR, REPLAY; ras_flush_o=(state==CLEAR), ras_push_o=(state==REPLAY), busy_o=(state!=IDLE).
REQ-020 Any state: flush_i or any commit strobe high in cycle t (commits only while state!=IDLE) -> state CLEAR at t+1; flush_i in IDLE -> CLEAR at t+1.
REQ-021 CLEAR, no restart event: count==0 -> IDLE; else REPLAY with ptr=count-1.
REQ-022 REPLAY: ras_data_o=arch[ptr]; ptr decrements each cycle; after ptr==0 push -> IDLE; oldest pushed first so arch[0] lands on top.
REQ-023 Flush at t with count=N>0 and no further events: ras_flush_o at t+1, pushes t+2..t+1+N, busy_o low at t+2+N.
REQ-024 Restart events in CLEAR/REPLAY SHALL restart from CLEAR with updated arch; partial pushes discarded by the new ras_flush_o.
REQ-025 ras_data_o SHALL be 0 outside REPLAY.
REQ-026 Commits in IDLE SHALL only update arch; no outputs.

Reset
REQ-027 rst_i high or clr_i: arch all 0, count=0, ptr=0, state IDLE.
REQ-028 Reset values: ras_flush_o=0, ras_push_o=0, ras_data_o=0, busy_o=0; mid-replay reset aborts with no further pushes.

Configuration
REQ-029 Macro RAS_REPLAY_PERF_EN defined: output ovf_cnt_o [15:0], saturating count of commit calls (without ret) with count==DEPTH; reset/clr to 0.
REQ-030 Macro undefined: ovf_cnt_o port and its counter absent; all other behaviour identical.

Verification (DEPTH=2)
REQ-031 Reset asserted mid-REPLAY -> all outputs 0 at once, busy_o 0, no push after release.
REQ-032 Calls 0x1000 then 0x2000, flush at t -> ras_flush_o t+1; push 0x1000 t+2; push 0x2000 t+3; busy_o 0 at t+4.
REQ-033 Calls 0x1,0x2,0x3, flush -> pushes 0x2 then 0x3; with RAS_REPLAY_PERF_EN ovf_cnt_o=1.
REQ-034 Call 0x1000, ret, flush at t -> ras_flush_o t+1, no push, busy_o 0 at t+2.
REQ-035 Two entries, flush; commit call 0x3000 during first REPLAY cycle -> ras_flush_o next cycle, then pushes 0x1000 (old top), 0x3000.
REQ-036 Empty stack, call+ret same cycle ra 0x4000, flush -> single push 0x4000.
